// File: rtl/sysid_boot_checker.sv
// Boot-time system ID checker: an Avalon-MM read master that fetches the ID and
// build timestamp words, compares them to build-time constants and retries on mismatch.
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1465338206,
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 2,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [3:0]  attempts
);

   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  LAT_L     = 2'(READ_LATENCY);
   localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRIES);
   localparam bit          LAT_ZERO  = (READ_LATENCY == 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_LAT_ID,
      S_RD_TS,
      S_LAT_TS,
      S_CHECK,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_pending;
   logic [15:0] r_to_cnt;
   logic [1:0]  r_lat_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic        r_id_mm;
   logic        r_ts_mm;
   logic        r_timeout;
   logic [31:0] r_id_value;
   logic [31:0] r_ts_value;
   logic [3:0]  r_attempts;

   logic w_rd;
   logic w_lat;
   logic w_accept;
   logic w_id_ok;
   logic w_ts_ok;
   logic w_launch;
   logic w_cap_id;
   logic w_cap_ts;
   logic w_to_hit;
   logic w_chk_ok;
   logic w_chk_fail;
   logic w_retry;
   logic w_finish;

   // Read strobe and word select decode straight from the state register, so an
   // asynchronous reset drops them at once, even mid-transfer.
   assign w_rd     = (r_state == S_RD_ID) || (r_state == S_RD_TS);
   assign w_lat    = (r_state == S_LAT_ID) || (r_state == S_LAT_TS);
   assign w_accept = w_rd & ~avm_waitrequest;
   assign w_id_ok  = (r_id_value == EXPECTED_ID);
   assign w_ts_ok  = (r_ts_value == EXPECTED_TS);
   assign w_finish = w_to_hit | w_chk_ok | w_chk_fail;

   // NOTE: every signal driven here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_cap_id    = 1'b0;
      w_cap_ts    = 1'b0;
      w_to_hit    = 1'b0;
      w_chk_ok    = 1'b0;
      w_chk_fail  = 1'b0;
      w_retry     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start || r_pending) begin
               w_launch    = 1'b1;
               w_state_nxt = S_RD_ID;
            end
         end
         S_RD_ID: begin
            if (!avm_waitrequest) begin
               if (LAT_ZERO) begin
                  w_cap_id    = 1'b1;
                  w_state_nxt = S_RD_TS;
               end else begin
                  w_state_nxt = S_LAT_ID;
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_to_hit    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_LAT_ID: begin
            if (r_lat_cnt == LAT_L) begin
               w_cap_id    = 1'b1;
               w_state_nxt = S_RD_TS;
            end
         end
         S_RD_TS: begin
            if (!avm_waitrequest) begin
               if (LAT_ZERO) begin
                  w_cap_ts    = 1'b1;
                  w_state_nxt = S_CHECK;
               end else begin
                  w_state_nxt = S_LAT_TS;
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_to_hit    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_LAT_TS: begin
            if (r_lat_cnt == LAT_L) begin
               w_cap_ts    = 1'b1;
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_id_ok && w_ts_ok) begin
               w_chk_ok    = 1'b1;
               w_state_nxt = S_DONE;
            end else if (r_attempts <= RETRY_LIM) begin
               w_retry     = 1'b1;
               w_state_nxt = S_RD_ID;
            end else begin
               w_chk_fail  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pending  <= AUTO_START;
         r_to_cnt   <= '0;
         r_lat_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_id_mm    <= 1'b0;
         r_ts_mm    <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= '0;
         r_ts_value <= '0;
         r_attempts <= '0;
      end else begin
         if (w_launch) r_pending <= 1'b0;

         // Stall budget is per read: restart on acceptance, new check or expiry.
         if (w_launch || w_accept || w_to_hit) r_to_cnt <= '0;
         else if (w_rd && avm_waitrequest)     r_to_cnt <= r_to_cnt + 16'd1;

         if (w_accept)   r_lat_cnt <= 2'd1;
         else if (w_lat) r_lat_cnt <= r_lat_cnt + 2'd1;

         if (w_launch)      r_busy <= 1'b1;
         else if (w_finish) r_busy <= 1'b0;

         if (w_launch)      r_done <= 1'b0;
         else if (w_finish) r_done <= 1'b1;

         if (w_launch)      r_pass <= 1'b0;
         else if (w_chk_ok) r_pass <= 1'b1;

         if (w_launch) begin
            r_id_mm <= 1'b0;
            r_ts_mm <= 1'b0;
         end else if (r_state == S_CHECK) begin
            r_id_mm <= ~w_id_ok;
            r_ts_mm <= ~w_ts_ok;
         end

         if (w_launch)      r_timeout <= 1'b0;
         else if (w_to_hit) r_timeout <= 1'b1;

         if (w_cap_id) r_id_value <= avm_readdata;
         if (w_cap_ts) r_ts_value <= avm_readdata;

         if (w_launch)     r_attempts <= 4'd1;
         else if (w_retry) r_attempts <= r_attempts + 4'd1;
      end
   end

   assign avm_read    = w_rd;
   assign avm_address = (r_state == S_RD_TS);
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign id_mismatch = r_id_mm;
   assign ts_mismatch = r_ts_mm;
   assign timeout     = r_timeout;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;
   assign attempts    = r_attempts;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two instances (read latency 0 and 2) each driven by
// a procedural model that plays the slave and predicts every output cycle by cycle.
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1465338206;
   localparam int          TO     = 10;
   localparam int          MAXR   = 2;

   logic        clk;
   logic        rst     [2];
   logic        start   [2];
   logic        addr    [2];
   logic        rd      [2];
   logic [31:0] rdata   [2];
   logic        wr      [2];
   logic        busy_o  [2];
   logic        done_o  [2];
   logic        pass_o  [2];
   logic        idm_o   [2];
   logic        tsm_o   [2];
   logic        to_o    [2];
   logic [31:0] idv_o   [2];
   logic [31:0] tsv_o   [2];
   logic [3:0]  att_o   [2];

   bit          e_read [2], e_addr [2], e_busy [2], e_done [2];
   bit          e_pass [2], e_idm [2], e_tsm [2], e_to [2];
   logic [31:0] e_idv  [2], e_tsv [2];
   logic [3:0]  e_att  [2];

   logic [31:0] idw [2][8];
   logic [31:0] tsw [2][8];
   bit          cur_busy [2];
   int          mode   [2];
   int          fstall [2];
   int          cyc    [2];
   int          rd_cnt [2];

   int n_tests = 0;
   int n_fail  = 0;

   sysid_boot_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
      .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR), .AUTO_START(1'b1)
   ) u_dut0 (
      .clock(clk), .reset(rst[0]), .start(start[0]),
      .avm_address(addr[0]), .avm_read(rd[0]), .avm_readdata(rdata[0]),
      .avm_waitrequest(wr[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .id_mismatch(idm_o[0]), .ts_mismatch(tsm_o[0]), .timeout(to_o[0]),
      .id_value(idv_o[0]), .ts_value(tsv_o[0]), .attempts(att_o[0])
   );

   sysid_boot_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2),
      .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR), .AUTO_START(1'b1)
   ) u_dut1 (
      .clock(clk), .reset(rst[1]), .start(start[1]),
      .avm_address(addr[1]), .avm_read(rd[1]), .avm_readdata(rdata[1]),
      .avm_waitrequest(wr[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .id_mismatch(idm_o[1]), .ts_mismatch(tsm_o[1]), .timeout(to_o[1]),
      .id_value(idv_o[1]), .ts_value(tsv_o[1]), .attempts(att_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, k, $time, act, exp);
      end
   endtask

   task automatic compare(input int k);
      check("avm_read", k, 32'(rd[k]), 32'(e_read[k]));
      if (e_read[k]) check("avm_address", k, 32'(addr[k]), 32'(e_addr[k]));
      check("busy", k, 32'(busy_o[k]), 32'(e_busy[k]));
      check("done", k, 32'(done_o[k]), 32'(e_done[k]));
      check("pass", k, 32'(pass_o[k]), 32'(e_pass[k]));
      check("id_mismatch", k, 32'(idm_o[k]), 32'(e_idm[k]));
      check("ts_mismatch", k, 32'(tsm_o[k]), 32'(e_tsm[k]));
      check("timeout", k, 32'(to_o[k]), 32'(e_to[k]));
      check("id_value", k, idv_o[k], e_idv[k]);
      check("ts_value", k, tsv_o[k], e_tsv[k]);
      check("attempts", k, 32'(att_o[k]), 32'(e_att[k]));
      cur_busy[k] = e_busy[k];
      if (rd[k] === 1'b1) rd_cnt[k]++;
   endtask

   // Advance one cycle; a busy checker gets random (ignored) start pulses.
   task automatic step(input int k);
      if (cur_busy[k]) start[k] = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      start[k] = 1'b0;
      cyc[k]++;
      compare(k);
   endtask

   task automatic capture(input int k, input bit a, input logic [31:0] word);
      if (a == 1'b0) e_idv[k] = word;
      else           e_tsv[k] = word;
      if (a == 1'b0) begin
         e_read[k] = 1'b1;
         e_addr[k] = 1'b1;
      end else begin
         e_read[k] = 1'b0;
      end
   endtask

   // One slave read as seen from the master: stalls, acceptance, latency, capture.
   task automatic do_read(input int k, input bit a, input logic [31:0] word, output bit to);
      int n   = 0;
      int f   = fstall[k];
      bit fin = 1'b0;
      bit ws;
      to = 1'b0;
      while (!fin) begin
         if (f > 0) begin
            ws = 1'b1;
            f--;
         end else if (mode[k] == 2) ws = 1'b1;
         else if (mode[k] == 1)     ws = ($urandom_range(0, 2) == 0);
         else                       ws = 1'b0;
         wr[k]    = ws;
         rdata[k] = $urandom;
         if (ws) begin
            n++;
            if (n == TO) begin
               e_read[k] = 1'b0;
               e_to[k]   = 1'b1;
               e_busy[k] = 1'b0;
               e_done[k] = 1'b1;
               to        = 1'b1;
               fin       = 1'b1;
            end
            step(k);
         end else begin
            fin = 1'b1;
            if (lat(k) == 0) begin
               rdata[k] = word;
               capture(k, a, word);
               step(k);
            end else begin
               e_read[k] = 1'b0;
               step(k);
               for (int i = 1; i <= lat(k); i++) begin
                  wr[k]    = 1'($urandom_range(0, 1));
                  rdata[k] = (i == lat(k)) ? word : $urandom;
                  if (i == lat(k)) capture(k, a, word);
                  step(k);
               end
            end
         end
      end
   endtask

   task automatic begin_check(input int k);
      wr[k]     = 1'($urandom_range(0, 1));
      rdata[k]  = $urandom;
      e_busy[k] = 1'b1; e_done[k] = 1'b0; e_pass[k] = 1'b0; e_to[k] = 1'b0;
      e_idm[k]  = 1'b0; e_tsm[k]  = 1'b0; e_att[k]  = 4'd1;
      e_read[k] = 1'b1; e_addr[k] = 1'b0;
      step(k);
   endtask

   task automatic body(input int k);
      int a   = 1;
      bit fin = 1'b0;
      bit to;
      while (!fin) begin
         do_read(k, 1'b0, idw[k][a-1], to);
         if (to) fin = 1'b1;
         else begin
            do_read(k, 1'b1, tsw[k][a-1], to);
            if (to) fin = 1'b1;
            else begin
               wr[k]    = 1'($urandom_range(0, 1));
               rdata[k] = $urandom;
               e_idm[k] = (e_idv[k] != EXP_ID);
               e_tsm[k] = (e_tsv[k] != EXP_TS);
               if (!e_idm[k] && !e_tsm[k]) begin
                  e_pass[k] = 1'b1; e_busy[k] = 1'b0; e_done[k] = 1'b1; fin = 1'b1;
               end else if (a <= MAXR) begin
                  a++;
                  e_att[k]  = 4'(a);
                  e_read[k] = 1'b1;
                  e_addr[k] = 1'b0;
               end else begin
                  e_busy[k] = 1'b0; e_done[k] = 1'b1; fin = 1'b1;
               end
               step(k);
            end
         end
      end
   endtask

   task automatic run_check(input int k);
      begin_check(k);
      body(k);
   endtask

   task automatic idle(input int k, input int n);
      repeat (n) begin
         wr[k]    = 1'($urandom_range(0, 1));
         rdata[k] = $urandom;
         step(k);
      end
   endtask

   task automatic fill_good(input int k);
      for (int i = 0; i < 8; i++) begin
         idw[k][i] = EXP_ID;
         tsw[k][i] = EXP_TS;
      end
   endtask

   // Reset is asserted between edges; outputs must clear with no clock edge.
   task automatic do_reset(input int k, input int n);
      rst[k] = 1'b1;
      #1;
      e_read[k] = 1'b0; e_addr[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
      e_pass[k] = 1'b0; e_idm[k]  = 1'b0; e_tsm[k]  = 1'b0; e_to[k]   = 1'b0;
      e_idv[k]  = '0;   e_tsv[k]  = '0;   e_att[k]  = '0;
      check("rst_read_drop", k, 32'(rd[k]), 32'd0);
      compare(k);
      repeat (n) begin
         @(negedge clk);
         compare(k);
      end
      rst[k] = 1'b0;
   endtask

   task automatic run_tb(input int k);
      int c0;
      start[k] = 1'b0; wr[k] = 1'b0; rdata[k] = '0;
      mode[k] = 0; fstall[k] = 0; cyc[k] = 0; rd_cnt[k] = 0;
      fill_good(k);
      do_reset(k, 2);

      // Auto-start after reset with a well-behaved slave.
      c0 = cyc[k];
      rd_cnt[k] = 0;
      run_check(k);
      if (lat(k) == 0) check("boot_cycles", k, 32'(cyc[k] - c0), 32'd4);
      check("boot_done", k, 32'(done_o[k]), 32'd1);
      check("boot_pass", k, 32'(pass_o[k]), 32'd1);
      check("boot_attempts", k, 32'(att_o[k]), 32'd1);
      check("boot_read_cycles", k, 32'(rd_cnt[k]), 32'd2);
      idle(k, 3);

      // Persistently wrong ID exhausts the retries.
      for (int i = 0; i < 8; i++) idw[k][i] = 32'h5;
      start[k] = 1'b1;
      run_check(k);
      check("badid_pass", k, 32'(pass_o[k]), 32'd0);
      check("badid_idm", k, 32'(idm_o[k]), 32'd1);
      check("badid_tsm", k, 32'(tsm_o[k]), 32'd0);
      check("badid_attempts", k, 32'(att_o[k]), 32'd3);
      check("badid_value", k, idv_o[k], 32'h5);
      idle(k, 2);

      // Timestamp wrong on the first pass only.
      fill_good(k);
      tsw[k][0] = EXP_TS ^ 32'h100;
      start[k] = 1'b1;
      run_check(k);
      check("ts_retry_pass", k, 32'(pass_o[k]), 32'd1);
      check("ts_retry_attempts", k, 32'(att_o[k]), 32'd2);
      check("ts_retry_tsm", k, 32'(tsm_o[k]), 32'd0);
      idle(k, 2);

      // Slave stuck in waitrequest.
      fill_good(k);
      mode[k] = 2;
      rd_cnt[k] = 0;
      start[k] = 1'b1;
      run_check(k);
      check("stuck_read_cycles", k, 32'(rd_cnt[k]), 32'd10);
      check("stuck_timeout", k, 32'(to_o[k]), 32'd1);
      check("stuck_pass", k, 32'(pass_o[k]), 32'd0);
      check("stuck_read_low", k, 32'(rd[k]), 32'd0);
      mode[k] = 0;
      idle(k, 2);

      // Three stall cycles on every read.
      fstall[k] = 3;
      rd_cnt[k] = 0;
      start[k] = 1'b1;
      run_check(k);
      check("stall3_pass", k, 32'(pass_o[k]), 32'd1);
      check("stall3_read_cycles", k, 32'(rd_cnt[k]), 32'd8);
      fstall[k] = 0;
      idle(k, 2);

      // Random slave stalls and random word correctness per pass.
      mode[k] = 1;
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 8; i++) begin
            idw[k][i] = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            tsw[k][i] = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
         end
         start[k] = 1'b1;
         run_check(k);
         idle(k, $urandom_range(1, 3));
      end
      mode[k] = 0;
      fill_good(k);

      // Reset in the middle of the timestamp read, then auto-restart from word 0.
      start[k] = 1'b1;
      begin_check(k);
      begin
         bit to;
         do_read(k, 1'b0, EXP_ID, to);
      end
      wr[k] = 1'b1;
      step(k);
      wr[k] = 1'b1;
      step(k);
      do_reset(k, 2);
      run_check(k);
      check("restart_pass", k, 32'(pass_o[k]), 32'd1);
      check("restart_attempts", k, 32'(att_o[k]), 32'd1);
      idle(k, 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      fork
         run_tb(0);
         run_tb(1);
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
